n64_reply_serializer: RTL and testbench

Parametrised N64-side reply transmitter for the GameCube-to-N64 adapter. It holds a reply frame of up to MAX_BYTES bytes in an internal buffer, loaded by the command decoder while idle. On `start` it serialises the frame MSB-first onto the open-drain N64 data line using 4-quarter bit cells, then appends a configurable stop bit. It replaces the per-reply hard-coded shift registers (controller state, status, pak insert, pak read, rumble) with one engine driven by a byte buffer and a length.

---
 rtl/n64_pkg.sv | 20 ++
 rtl/n64_quarter_timer.sv | 38 +++
 rtl/n64_reply_serializer.sv | 148 ++++++++++++++
 tb/tb_n64_reply_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared types and constants for the N64 reply transmitter.
package n64_pkg;

    localparam int QUARTERS_PER_BIT = 4;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } tx_state_t;

    // Canned reply bytes the command decoder loads into the buffer
    localparam logic [7:0] STATUS_B0      = 8'h05;
    localparam logic [7:0] STATUS_B1      = 8'h00;
    localparam logic [7:0] STATUS_B2      = 8'h01;
    localparam logic [7:0] PAK_INSERTED   = 8'hE1;
    localparam logic [7:0] RUMBLE_PAK_ID  = 8'h80;
    localparam logic [7:0] RUMBLE_PAK_ALT = 8'hB8;

endpackage

// File: rtl/n64_quarter_timer.sv
// Restartable quarter-bit prescaler: ticks every CLKS_PER_QUARTER enabled
// cycles and keeps a wrapping 2-bit quarter index within the bit cell.
module n64_quarter_timer #(
    parameter int CLKS_PER_QUARTER = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       en,
    output logic       quarter_tick,
    output logic [1:0] quarter_idx
);

    localparam int CNT_W = (CLKS_PER_QUARTER > 1) ? $clog2(CLKS_PER_QUARTER) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_QUARTER - 1);

    logic [CNT_W-1:0] cnt;

    // Tick on the last cycle of a quarter so the owner updates on quarter boundaries
    assign quarter_tick = en && (cnt == LAST);

    // Prescaler only runs while enabled; restart realigns it to a fresh q0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            quarter_idx <= '0;
        end else if (restart) begin
            cnt         <= '0;
            quarter_idx <= '0;
        end else if (quarter_tick) begin
            cnt         <= '0;
            quarter_idx <= quarter_idx + 2'd1;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/n64_reply_serializer.sv
// N64 reply transmitter: byte buffer plus a bit-cell serializer that drives
// the open-drain data line MSB-first with a trailing stop bit.
module n64_reply_serializer
    import n64_pkg::*;
#(
    parameter int MAX_BYTES         = 33,
    parameter int CLKS_PER_QUARTER  = 28,
    parameter int STOP_LOW_QUARTERS = 2,
    parameter int ADDR_W            = $clog2(MAX_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_err,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              start_err,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              line_oe
);

    tx_state_t         state;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] byte_idx;
    logic [2:0]        bit_idx;
    logic [7:0]        cur_byte;
    logic [7:0]        mem [MAX_BYTES];

    logic       q_tick;
    logic [1:0] q_idx;
    logic       addr_bad, len_ok, accept, wr_ok, last_byte;
    logic [7:0] byte0;
    logic [1:0] next_q;

    assign addr_bad  = 32'(wr_addr) >= 32'(MAX_BYTES);
    assign len_ok    = (len != '0) && (32'(len) <= 32'(MAX_BYTES));
    assign accept    = (state == IDLE) && start && !abort && len_ok;
    assign wr_ok     = wr_en && (state == IDLE) && !addr_bad;
    // A write landing with the accepted start must be the byte that goes out
    assign byte0     = (wr_ok && wr_addr == '0) ? wr_data : mem[0];
    assign last_byte = ({1'b0, byte_idx} == len_q - (ADDR_W+1)'(1));
    assign next_q    = q_idx + 2'd1;

    n64_quarter_timer #(
        .CLKS_PER_QUARTER(CLKS_PER_QUARTER)
    ) u_qtimer (
        .clk         (clk),
        .rst         (rst),
        .restart     (accept),
        .en          (state != IDLE),
        .quarter_tick(q_tick),
        .quarter_idx (q_idx)
    );

    // Reply buffer: contents survive reset and frames, writable only while idle
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
    end

    // Frame sequencer; line_oe is always set for the quarter being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            line_oe   <= 1'b0;
            start_err <= 1'b0;
            wr_err    <= 1'b0;
            len_q     <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            cur_byte  <= '0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            wr_err    <= wr_en && ((state != IDLE) || addr_bad);
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (len_ok) begin
                            state    <= DATA;
                            busy     <= 1'b1;
                            line_oe  <= 1'b1;
                            len_q    <= len;
                            byte_idx <= '0;
                            bit_idx  <= 3'd7;
                            cur_byte <= byte0;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        line_oe <= 1'b0;
                    end else if (q_tick) begin
                        case (q_idx)
                            2'd0, 2'd1: line_oe <= ~cur_byte[bit_idx];
                            2'd2:       line_oe <= 1'b0;
                            default: begin
                                line_oe <= 1'b1;
                                if (bit_idx == 3'd0) begin
                                    if (last_byte) begin
                                        state <= STOP;
                                    end else begin
                                        byte_idx <= byte_idx + ADDR_W'(1);
                                        cur_byte <= mem[byte_idx + ADDR_W'(1)];
                                        bit_idx  <= 3'd7;
                                    end
                                end else begin
                                    bit_idx <= bit_idx - 3'd1;
                                end
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        line_oe <= 1'b0;
                    end else if (q_tick) begin
                        if (q_idx == 2'd3) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            line_oe <= 1'b0;
                        end else begin
                            line_oe <= 32'(next_q) < 32'(STOP_LOW_QUARTERS);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    line_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_n64_reply_serializer.sv
// Directed bench for the N64 reply serializer (CLKS_PER_QUARTER=4).
module tb_n64_reply_serializer;

    localparam int MAXB = 33;
    localparam int CPQ  = 4;
    localparam int SLQ  = 2;
    localparam int AW   = $clog2(MAXB);
    localparam int BITC = 4 * CPQ;
    localparam int LIM  = 6000;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_err;
    logic [AW:0]   len;
    logic          start;
    logic          start_err;
    logic          abort;
    logic          busy;
    logic          done;
    logic          line_oe;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [7:0] exp_b [MAXB];
    logic       line_s [LIM];

    always #5 clk = ~clk;

    n64_reply_serializer #(
        .MAX_BYTES        (MAXB),
        .CLKS_PER_QUARTER (CPQ),
        .STOP_LOW_QUARTERS(SLQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .len      (len),
        .start    (start),
        .start_err(start_err),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .line_oe  (line_oe)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d, output logic err);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
        @(negedge clk);
        err = wr_err; wr_en = 1'b0;
    endtask

    // Expected line level for sample i of an n-byte frame
    function automatic logic exp_line(input int i, input int n);
        int j, q;
        logic [7:0] b;
        j = i / BITC;
        q = (i % BITC) / CPQ;
        if (j < 8 * n) begin
            b = exp_b[j / 8];
            if (q == 0) return 1'b1;
            if (q == 3) return 1'b0;
            return ~b[7 - (j % 8)];
        end
        return q < SLQ;
    endfunction

    // Start an n-byte frame and check it end to end. mid_k > 0 pokes a
    // write and a start at that frame sample; wr0 rewrites byte 0 with start.
    task automatic send_frame(input string tag, input int n, input int mid_k, input bit wr0);
        int k, nb, errs, done_seen;
        logic [7:0] dec;
        @(negedge clk);
        len = (AW+1)'(n); start = 1'b1;
        if (wr0) begin wr_en = 1'b1; wr_addr = '0; wr_data = exp_b[0]; end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        k = 1; done_seen = 0;
        while (busy === 1'b1 && k < LIM) begin
            if (mid_k > 0 && k == mid_k + 1) begin
                chk({tag, ":wr_err_busy"}, 32'(wr_err), 1);
                chk({tag, ":start_busy_err"}, 32'(start_err), 0);
            end
            line_s[k-1] = line_oe;
            if (done === 1'b1) done_seen++;
            if (k == mid_k) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 8'hFF; start = 1'b1;
            end
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            k++;
        end
        nb = k - 1;
        chk({tag, ":busy_len"}, nb, (8 * n + 1) * BITC);
        chk({tag, ":done_end"}, 32'(done), 1);
        chk({tag, ":done_early"}, done_seen, 0);
        errs = 0;
        for (int i = 0; i < nb && i < (8 * n + 1) * BITC; i++)
            if (line_s[i] !== exp_line(i, n)) errs++;
        chk({tag, ":wave_errs"}, errs, 0);
        if (nb == (8 * n + 1) * BITC) begin
            for (int y = 0; y < n; y++) begin
                for (int bb = 0; bb < 8; bb++)
                    dec[7 - bb] = ~line_s[(8 * y + bb) * BITC + CPQ];
                chk($sformatf("%s:byte%0d", tag, y), 32'(dec), 32'(exp_b[y]));
            end
        end
        @(negedge clk);
        chk({tag, ":done_once"}, 32'(done), 0);
    endtask

    initial begin
        logic e;
        int   dcnt;
        logic [AW:0] bad_len [2];
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = '0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst:line_oe", 32'(line_oe), 0);
        chk("rst:busy", 32'(busy), 0);
        chk("rst:done", 32'(done), 0);
        chk("rst:wr_err", 32'(wr_err), 0);
        chk("rst:start_err", 32'(start_err), 0);
        rst = 1'b0;

        // Status reply
        exp_b[0] = 8'h05; exp_b[1] = 8'h00; exp_b[2] = 8'h01;
        for (int i = 0; i < 3; i++) begin
            wr(i, exp_b[i], e);
            chk($sformatf("wr%0d:err", i), 32'(e), 0);
        end
        send_frame("status", 3, 0, 1'b0);
        send_frame("resend", 3, 0, 1'b0);

        // Full-depth rumble pak read
        for (int i = 0; i < 32; i++) exp_b[i] = 8'h80;
        exp_b[32] = 8'hB8;
        for (int i = 0; i < 33; i++) wr(i, exp_b[i], e);
        send_frame("pak33", 33, 0, 1'b0);

        // Illegal lengths
        bad_len[0] = '0; bad_len[1] = (AW+1)'(34);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); len = bad_len[i]; start = 1'b1;
            @(negedge clk); start = 1'b0;
            chk($sformatf("len%0d:start_err", bad_len[i]), 32'(start_err), 1);
            chk($sformatf("len%0d:busy", bad_len[i]), 32'(busy), 0);
            chk($sformatf("len%0d:line", bad_len[i]), 32'(line_oe), 0);
            @(negedge clk);
            chk($sformatf("len%0d:err_pulse", bad_len[i]), 32'(start_err), 0);
            chk($sformatf("len%0d:line2", bad_len[i]), 32'(line_oe), 0);
        end

        // Abort together with start while idle: nothing happens
        @(negedge clk); len = 3; start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("ab_start:busy", 32'(busy), 0);
        chk("ab_start:start_err", 32'(start_err), 0);
        chk("ab_start:line", 32'(line_oe), 0);

        // Abort during bit 3 of byte 1, then immediate restart
        exp_b[0] = 8'hA5; exp_b[1] = 8'h3C; exp_b[2] = 8'h0F;
        for (int i = 0; i < 3; i++) wr(i, exp_b[i], e);
        @(negedge clk); len = 3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (11 * BITC + 2) @(negedge clk);
        chk("abort:pre_line", 32'(line_oe), 1);
        chk("abort:pre_busy", 32'(busy), 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort:line", 32'(line_oe), 0);
        chk("abort:busy", 32'(busy), 0);
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("abort:no_done", dcnt, 0);
        send_frame("restart", 3, 0, 1'b0);

        // Writes and start while busy are rejected/ignored
        send_frame("busy_wr", 3, 37, 1'b0);
        send_frame("after_busy_wr", 3, 0, 1'b0);
        wr(40, 8'h11, e);
        chk("wr40:err", 32'(e), 1);
        wr(33, 8'h11, e);
        chk("wr33:err", 32'(e), 1);
        wr(32, 8'h11, e);
        chk("wr32:err", 32'(e), 0);

        // Asynchronous reset mid-q0 of bit 2
        @(negedge clk); len = 3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2 * BITC + 1) @(negedge clk);
        chk("arst:pre_line", 32'(line_oe), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst:line", 32'(line_oe), 0);
        chk("arst:busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("arst:no_done", dcnt, 0);

        // Restart after reset, rewriting byte 0 in the start cycle
        exp_b[0] = 8'hC3;
        send_frame("post_rst_wr0", 3, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
